// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: command codes, ALU op selects,
// FSM encoding and the command-to-ALU-control decode.
package alu_pkg;

  localparam logic [1:0] CMD_AND = 2'b00;
  localparam logic [1:0] CMD_OR  = 2'b01;
  localparam logic [1:0] CMD_ADD = 2'b10;
  localparam logic [1:0] CMD_SUB = 2'b11;

  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_OR    = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic       binv;
    logic       cin;
  } alu_ctrl_t;

  // SUB is a + ~b + 1 on the shared adder.
  function automatic alu_ctrl_t decode_cmd(input logic [1:0] code);
    alu_ctrl_t c;
    c = '{op: OP_AND, binv: 1'b0, cin: 1'b0};
    case (code)
      CMD_AND: c = '{op: OP_AND,   binv: 1'b0, cin: 1'b0};
      CMD_OR:  c = '{op: OP_OR,    binv: 1'b0, cin: 1'b0};
      CMD_ADD: c = '{op: OP_ARITH, binv: 1'b0, cin: 1'b0};
      CMD_SUB: c = '{op: OP_ARITH, binv: 1'b1, cin: 1'b1};
      default: c = '{op: OP_AND,   binv: 1'b0, cin: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_flags.sv
// Combinational status flags for a completed ALU operation (carry, zero, negative,
// signed overflow); carry and overflow are only meaningful for ADD/SUB.
module alu_flags
  import alu_pkg::*;
(
  input  logic [1:0]  code,
  input  logic        a_msb,
  input  logic        b_msb,
  input  logic [31:0] result,
  input  logic        cout,
  output logic        carry,
  output logic        zero,
  output logic        neg,
  output logic        ovf
);

  always_comb begin
    carry = 1'b0;
    ovf   = 1'b0;
    zero  = (result == 32'd0);
    neg   = result[31];
    case (code)
      CMD_ADD: begin
        carry = cout;
        ovf   = (a_msb == b_msb) && (result[31] != a_msb);
      end
      CMD_SUB: begin
        carry = cout;
        ovf   = (a_msb != b_msb) && (result[31] != a_msb);
      end
      default: begin
        carry = 1'b0;
        ovf   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to an external combinational ALU: IDLE -> EXEC -> RESP,
// 3 cycles minimum per command; the response is held in RESP until rsp_ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_code,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_binv,
  output logic             alu_cin,
  input  logic [31:0]      alu_result,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_ovf,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] ops_done
);

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  alu_ctrl_t        ctrl_q, ctrl_d;
  logic [1:0]       code_q, code_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic f_carry, f_zero, f_neg, f_ovf;

  alu_flags u_flags (
    .code   (code_q),
    .a_msb  (a_q[31]),
    .b_msb  (b_q[31]),
    .result (alu_result),
    .cout   (alu_cout),
    .carry  (f_carry),
    .zero   (f_zero),
    .neg    (f_neg),
    .ovf    (f_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      code_q   <= '0;
      tag_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      code_q   <= code_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      ops_q    <= ops_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    code_d   = code_q;
    tag_d    = tag_q;
    result_d = result_q;
    flags_d  = flags_q;
    ops_d    = ops_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          ctrl_d  = decode_cmd(cmd_code);
          code_d  = cmd_code;
          tag_d   = cmd_tag;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        flags_d  = {f_carry, f_zero, f_neg, f_ovf};
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ops_d   = ops_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The ALU operand/control registers are only reloaded on accept, so they
  // keep showing the last command outside EXEC.
  always_comb begin
    cmd_ready  = (state_q == IDLE);
    rsp_valid  = (state_q == RESP);
    alu_a      = a_q;
    alu_b      = b_q;
    alu_op     = ctrl_q.op;
    alu_binv   = ctrl_q.binv;
    alu_cin    = ctrl_q.cin;
    rsp_result = result_q;
    rsp_carry  = flags_q[3];
    rsp_zero   = flags_q[2];
    rsp_neg    = flags_q[1];
    rsp_ovf    = flags_q[0];
    rsp_tag    = tag_q;
    ops_done   = ops_q;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a companion ALU; directed cases plus random
// commands checked against an arithmetic reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_code;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        alu_binv, alu_cin, alu_cout;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_zero, rsp_neg, rsp_ovf;
  logic [3:0]  rsp_tag;
  logic [3:0]  ops_done;

  int errors = 0;
  int checks = 0;
  logic [3:0] ops_model = 4'd0;
  int completed = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.TAG_W(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_binv   (alu_binv),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg),
    .rsp_ovf    (rsp_ovf),
    .rsp_tag    (rsp_tag),
    .ops_done   (ops_done)
  );

  // Companion combinational ALU driven by the controller's registered ports.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, (alu_binv ? ~alu_b : alu_b)} + {32'd0, alu_cin};
    case (alu_op)
      2'b00:   alu_result = alu_a & alu_b;
      2'b01:   alu_result = alu_a | alu_b;
      default: alu_result = alu_sum[31:0];
    endcase
    alu_cout = (alu_op == 2'b10) ? alu_sum[32] : 1'b0;
  end

  typedef struct {
    logic [31:0] r;
    logic        c, z, n, v;
  } exp_t;

  function automatic exp_t ref_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s;
    e.c = 1'b0;
    e.v = 1'b0;
    case (code)
      2'b00: e.r = a & b;
      2'b01: e.r = a | b;
      2'b10: begin
        e.r = a + b;
        e.c = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
        s   = longint'($signed(a)) + longint'($signed(b));
        e.v = (s > SMAX) || (s < SMIN);
      end
      default: begin
        e.r = a - b;
        e.c = (a >= b);
        s   = longint'($signed(a)) - longint'($signed(b));
        e.v = (s > SMAX) || (s < SMIN);
      end
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  // Expected {alu_op, alu_binv, alu_cin} per command code.
  function automatic logic [3:0] exp_ctrl(input logic [1:0] code);
    case (code)
      2'b00:   return 4'b0000;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b1000;
      default: return 4'b1011;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge; inputs are driven there.
  task automatic run_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input int stall, input bit hold_valid);
    exp_t e;
    int   n;
    e = ref_op(code, a, b);
    cmd_valid = 1'b1; cmd_code = code; cmd_a = a; cmd_b = b; cmd_tag = tag;
    rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold_valid) begin
      cmd_valid = 1'b0;
      cmd_a = $urandom; cmd_b = $urandom; cmd_code = 2'($urandom); cmd_tag = 4'($urandom);
    end
    check("exec_ctrl", 64'({alu_op, alu_binv, alu_cin}), 64'(exp_ctrl(code)));
    check("exec_ops", {alu_a, alu_b}, {a, b});
    check("exec_busy", 64'({cmd_ready, rsp_valid}), 64'd0);
    @(negedge clk);
    for (int i = 0; i <= stall; i++) begin
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_result", 64'(rsp_result), 64'(e.r));
      check("rsp_flags", 64'({rsp_carry, rsp_zero, rsp_neg, rsp_ovf}), 64'({e.c, e.z, e.n, e.v}));
      check("rsp_tag", 64'(rsp_tag), 64'(tag));
      check("rsp_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rsp_alu_hold", {alu_a, alu_b}, {a, b});
      if (i == stall) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    ops_model = ops_model + 4'd1;
    completed++;
    check("ops_done", 64'(ops_done), 64'(ops_model));
    check("idle_after", 64'({cmd_ready, rsp_valid}), 64'b10);
    if (completed == 17) check("ops_wrap17", 64'(ops_done), 64'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corner [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_rsp;
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = 2'b00; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 64'({cmd_ready, rsp_valid}), 64'b10);
    check("reset_alu", {alu_a, alu_b}, 64'd0);
    check("reset_ctrl", 64'({alu_op, alu_binv, alu_cin}), 64'd0);
    check("reset_rsp", 64'({rsp_result, rsp_carry, rsp_zero, rsp_neg, rsp_ovf, rsp_tag}), 64'd0);
    check("reset_ops", 64'(ops_done), 64'd0);

    // Reset during EXEC drops the command; cmd_valid under reset is ignored.
    cmd_valid = 1'b1; cmd_code = 2'b10; cmd_a = 32'd9; cmd_b = 32'd3; cmd_tag = 4'h5;
    @(negedge clk);
    check("pre_rst_exec", 64'(cmd_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    check("rst_exec_idle", 64'({cmd_ready, rsp_valid}), 64'b10);
    check("rst_exec_ops", 64'(ops_done), 64'(ops_model));
    check("rst_exec_alu", {alu_a, alu_b}, 64'd0);
    check("rst_exec_ctrl", 64'({alu_op, alu_binv, alu_cin}), 64'd0);
    seen_rsp = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    rsp_ready = 1'b0;
    check("dropped_no_rsp", 64'(seen_rsp), 64'd0);
    check("dropped_ops", 64'(ops_done), 64'(ops_model));

    run_op(2'b00, 32'd5, 32'd50, 4'h1, 0, 1'b0);
    run_op(2'b01, 32'd5, 32'd50, 4'h2, 0, 1'b0);
    check("ops_after_and_or", 64'(ops_done), 64'd2);
    run_op(2'b10, 32'd5, 32'd50, 4'h3, 0, 1'b0);
    run_op(2'b11, 32'd5, 32'd50, 4'h4, 0, 1'b0);
    run_op(2'b11, 32'd50, 32'd5, 4'h5, 0, 1'b0);
    run_op(2'b10, 32'h7FFF_FFFF, 32'd1, 4'h6, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 4'h7, 0, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'd1, 4'h8, 0, 1'b0);
    // Backpressure with the next command already waiting on the channel.
    run_op(2'b10, 32'd100, 32'd23, 4'hA, 5, 1'b1);
    run_op(2'b10, 32'd100, 32'd23, 4'hA, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      run_op(2'($urandom), rand_operand(), rand_operand(), 4'($urandom),
             int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
